ped_signal_ctrl: RTL and testbench

PED_SIGNAL_CTRL -- requirements
Module: ped_signal_ctrl

---
 rtl/ped_pkg.sv | 21 ++
 rtl/ped_timer.sv | 26 ++
 rtl/ped_signal_ctrl.sv | 159 +++++++++++++++
 tb/tb_ped_signal_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/ped_pkg.sv
// Shared types for the pedestrian crossing controller: FSM states and vehicle lamp codes.
// No timing of its own; no backpressure.
package ped_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_RED,
        ST_WALK,
        ST_CLEAR,
        ST_DONE
    } state_t;

    localparam logic [2:0] COL_GREEN  = 3'b001;
    localparam logic [2:0] COL_YELLOW = 3'b010;
    localparam logic [2:0] COL_RED    = 3'b100;

    function automatic logic is_legal_colour(input logic [2:0] col);
        return (col == COL_GREEN) || (col == COL_YELLOW) || (col == COL_RED);
    endfunction

endpackage

// File: rtl/ped_timer.sv
// 4-bit loadable down-counter pacing the walk and clearance phases; load wins over enable.
// Zero flag reflects the registered count; counting stops at zero, no backpressure.
module ped_timer (
    input  logic       c,
    input  logic       r,
    input  logic       i_load,
    input  logic       i_en,
    input  logic [3:0] i_load_val,
    output logic       o_zero
);

    logic [3:0] r_cnt;

    always_ff @(posedge c) begin
        if (r) begin
            r_cnt <= 4'd0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    assign o_zero = (r_cnt == 4'd0);

endmodule

// File: rtl/ped_signal_ctrl.sv
// Pedestrian walk/don't-walk controller slaved to the vehicle lamp; all outputs registered, one cycle after the sampled event.
// Optional PED_COUNTDOWN_EN builds the clearance countdown register; otherwise countdown is tied to 0.
module ped_signal_ctrl
    import ped_pkg::*;
#(
    parameter int WALK_CYC  = 4,
    parameter int CLEAR_CYC = 3
) (
    input  logic       c,
    input  logic       r,
    input  logic [2:0] colour,
    input  logic       btn,
    output logic       walk,
    output logic       dont_walk,
    output logic       req_pending,
    output logic [3:0] countdown,
    output logic       fault
);

    localparam logic [3:0] WALK_LD  = 4'(WALK_CYC - 1);
    localparam logic [3:0] CLEAR_LD = 4'(CLEAR_CYC - 1);

    state_t     r_state;
    state_t     w_nxt_state;
    logic       r_walk;
    logic       r_dont_walk;
    logic       r_pend;
    logic       r_fault;
    logic       w_pend_nxt;
    logic       w_dw_nxt;
    logic       w_red;
    logic       w_bad;
    logic       w_load;
    logic       w_en;
    logic       w_zero;
    logic [3:0] w_load_val;

    assign w_red = (colour == COL_RED);
    assign w_bad = !is_legal_colour(colour);

    ped_timer u_timer (
        .c          (c),
        .r          (r),
        .i_load     (w_load),
        .i_en       (w_en),
        .i_load_val (w_load_val),
        .o_zero     (w_zero)
    );

    always_comb begin
        w_nxt_state = r_state;
        w_pend_nxt  = r_pend;
        w_load      = 1'b0;
        w_load_val  = WALK_LD;
        w_en        = 1'b0;
        if (w_bad || r_fault) begin
            w_nxt_state = ST_IDLE;
            w_pend_nxt  = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (btn) begin
                        w_nxt_state = ST_WAIT_RED;
                        w_pend_nxt  = 1'b1;
                    end
                end
                ST_WAIT_RED: begin
                    if (w_red) begin
                        w_nxt_state = ST_WALK;
                        w_pend_nxt  = 1'b0;
                        w_load      = 1'b1;
                    end
                end
                ST_WALK: begin
                    if (!w_red) begin
                        w_nxt_state = ST_IDLE;
                    end else if (w_zero) begin
                        w_nxt_state = ST_CLEAR;
                        w_load      = 1'b1;
                        w_load_val  = CLEAR_LD;
                    end else begin
                        w_en = 1'b1;
                    end
                end
                ST_CLEAR: begin
                    if (!w_red) begin
                        w_nxt_state = ST_IDLE;
                    end else if (w_zero) begin
                        w_nxt_state = ST_DONE;
                    end else begin
                        w_en = 1'b1;
                    end
                end
                ST_DONE: begin
                    // A press on the same edge the red ends still counts for the next crossing.
                    w_pend_nxt = r_pend | btn;
                    if (!w_red) begin
                        w_nxt_state = w_pend_nxt ? ST_WAIT_RED : ST_IDLE;
                    end
                end
                default: begin
                    w_nxt_state = ST_IDLE;
                end
            endcase
        end
    end

    // Flashing starts lit on CLEAR entry and alternates while CLEAR persists.
    always_comb begin
        w_dw_nxt = 1'b1;
        if (w_nxt_state == ST_WALK) begin
            w_dw_nxt = 1'b0;
        end else if ((w_nxt_state == ST_CLEAR) && (r_state == ST_CLEAR)) begin
            w_dw_nxt = ~r_dont_walk;
        end
    end

    always_ff @(posedge c) begin
        if (r) begin
            r_state     <= ST_IDLE;
            r_walk      <= 1'b0;
            r_dont_walk <= 1'b1;
            r_pend      <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            r_state     <= w_nxt_state;
            r_walk      <= (w_nxt_state == ST_WALK);
            r_dont_walk <= w_dw_nxt;
            r_pend      <= w_pend_nxt;
            r_fault     <= r_fault | w_bad;
        end
    end

`ifdef PED_COUNTDOWN_EN
    logic [3:0] r_countdown;

    always_ff @(posedge c) begin
        if (r) begin
            r_countdown <= 4'd0;
        end else if (w_nxt_state != ST_CLEAR) begin
            r_countdown <= 4'd0;
        end else if (r_state != ST_CLEAR) begin
            r_countdown <= 4'(CLEAR_CYC);
        end else begin
            r_countdown <= r_countdown - 4'd1;
        end
    end

    assign countdown = r_countdown;
`else
    assign countdown = 4'd0;
`endif

    assign walk        = r_walk;
    assign dont_walk   = r_dont_walk;
    assign req_pending = r_pend;
    assign fault       = r_fault;

endmodule

// File: tb/tb_ped_signal_ctrl.sv
// Bench for ped_signal_ctrl: directed vector table, hand-written corner sequences and random
// lamp/button traffic compared every cycle against a phase-and-elapsed-time reference model.
module tb_ped_signal_ctrl;

    localparam int WALK_CYC  = 4;
    localparam int CLEAR_CYC = 3;
`ifdef PED_COUNTDOWN_EN
    localparam bit CD_EN = 1'b1;
`else
    localparam bit CD_EN = 1'b0;
`endif

    localparam int P_IDLE  = 0;
    localparam int P_WAIT  = 1;
    localparam int P_WALK  = 2;
    localparam int P_CLEAR = 3;
    localparam int P_DONE  = 4;

    logic       c = 1'b0;
    logic       r = 1'b1;
    logic [2:0] colour = 3'b001;
    logic       btn = 1'b0;
    logic       walk;
    logic       dont_walk;
    logic       req_pending;
    logic [3:0] countdown;
    logic       fault;

    int total = 0;
    int bad   = 0;

    int m_phase = P_IDLE;
    int m_k     = 0;
    bit m_pend  = 1'b0;
    bit m_fault = 1'b0;

    typedef struct {
        logic       r;
        logic [2:0] col;
        logic       b;
        logic       w;
        logic       dw;
        logic       p;
        logic [3:0] cd;
        logic       f;
    } vec_t;

    vec_t tbl[16];

    always #5 c = ~c;

    ped_signal_ctrl #(
        .WALK_CYC  (WALK_CYC),
        .CLEAR_CYC (CLEAR_CYC)
    ) dut (
        .c           (c),
        .r           (r),
        .colour      (colour),
        .btn         (btn),
        .walk        (walk),
        .dont_walk   (dont_walk),
        .req_pending (req_pending),
        .countdown   (countdown),
        .fault       (fault)
    );

    function automatic vec_t mk(input logic rr, input logic [2:0] col, input logic b,
                                input logic w, input logic dw, input logic p,
                                input logic [3:0] cd, input logic f);
        vec_t v;
        v.r = rr; v.col = col; v.b = b; v.w = w; v.dw = dw; v.p = p; v.cd = cd; v.f = f;
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: which phase we are in and how many cycles we have spent there.
    task automatic model_step(input logic rr, input logic [2:0] col, input logic b);
        bit legal;
        bit red;
        legal = (col == 3'b001) || (col == 3'b010) || (col == 3'b100);
        red   = (col == 3'b100);
        if (rr) begin
            m_phase = P_IDLE; m_k = 0; m_pend = 1'b0; m_fault = 1'b0;
        end else if (m_fault || !legal) begin
            m_fault = 1'b1; m_phase = P_IDLE; m_pend = 1'b0;
        end else begin
            case (m_phase)
                P_IDLE: if (b) begin m_phase = P_WAIT; m_pend = 1'b1; end
                P_WAIT: if (red) begin m_phase = P_WALK; m_k = 0; m_pend = 1'b0; end
                P_WALK: begin
                    if (!red) m_phase = P_IDLE;
                    else if (m_k == WALK_CYC - 1) begin m_phase = P_CLEAR; m_k = 0; end
                    else m_k++;
                end
                P_CLEAR: begin
                    if (!red) m_phase = P_IDLE;
                    else if (m_k == CLEAR_CYC - 1) m_phase = P_DONE;
                    else m_k++;
                end
                default: begin
                    m_pend = m_pend | b;
                    if (!red) m_phase = m_pend ? P_WAIT : P_IDLE;
                end
            endcase
        end
    endtask

    task automatic cyc(input logic rr, input logic [2:0] col, input logic b);
        int exp_cd;
        bit exp_dw;
        r = rr; colour = col; btn = b;
        @(posedge c);
        model_step(rr, col, b);
        #1;
        exp_cd = (CD_EN && m_phase == P_CLEAR) ? (CLEAR_CYC - m_k) : 0;
        exp_dw = (m_phase != P_WALK) && !(m_phase == P_CLEAR && m_k % 2 == 1);
        chk("model_walk",      8'(walk),        8'(m_phase == P_WALK));
        chk("model_dont_walk", 8'(dont_walk),   8'(exp_dw));
        chk("model_pending",   8'(req_pending), 8'(m_pend));
        chk("model_countdown", 8'(countdown),   8'(exp_cd));
        chk("model_fault",     8'(fault),       8'(m_fault));
        chk("lamps_exclusive", 8'(walk & dont_walk), 8'd0);
    endtask

    initial begin
        logic [2:0] rcol;
        int         pick;

        // Reset, then a full crossing at default timing, then red ends.
        tbl[0]  = mk(1'b1, 3'b001, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
        tbl[1]  = mk(1'b0, 3'b001, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0);
        tbl[2]  = mk(1'b0, 3'b001, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0);
        tbl[3]  = mk(1'b0, 3'b100, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        tbl[4]  = mk(1'b0, 3'b100, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        tbl[5]  = mk(1'b0, 3'b100, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        tbl[6]  = mk(1'b0, 3'b100, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        tbl[7]  = mk(1'b0, 3'b100, 1'b0, 1'b0, 1'b1, 1'b0, 4'd3, 1'b0);
        tbl[8]  = mk(1'b0, 3'b100, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2, 1'b0);
        tbl[9]  = mk(1'b0, 3'b100, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 1'b0);
        tbl[10] = mk(1'b0, 3'b100, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
        tbl[11] = mk(1'b0, 3'b100, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
        tbl[12] = mk(1'b0, 3'b100, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
        tbl[13] = mk(1'b0, 3'b100, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
        tbl[14] = mk(1'b0, 3'b100, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
        tbl[15] = mk(1'b0, 3'b010, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);

        for (int i = 0; i < 16; i++) begin
            cyc(tbl[i].r, tbl[i].col, tbl[i].b);
            chk("vec_walk",      8'(walk),        8'(tbl[i].w));
            chk("vec_dont_walk", 8'(dont_walk),   8'(tbl[i].dw));
            chk("vec_pending",   8'(req_pending), 8'(tbl[i].p));
            chk("vec_countdown", 8'(countdown),   CD_EN ? 8'(tbl[i].cd) : 8'd0);
            chk("vec_fault",     8'(fault),       8'(tbl[i].f));
        end

        // Red ends during the second walk cycle.
        cyc(1'b0, 3'b001, 1'b1);
        cyc(1'b0, 3'b100, 1'b0);
        cyc(1'b0, 3'b100, 1'b0);
        chk("abort_walk2_on", 8'(walk), 8'd1);
        cyc(1'b0, 3'b010, 1'b0);
        chk("abort_walk", 8'(walk), 8'd0);
        chk("abort_dw",   8'(dont_walk), 8'd1);
        chk("abort_pend", 8'(req_pending), 8'd0);

        // Button together with red arrival in IDLE only arms the request.
        cyc(1'b0, 3'b100, 1'b1);
        chk("coincide_no_walk", 8'(walk), 8'd0);
        chk("coincide_pend",    8'(req_pending), 8'd1);
        cyc(1'b0, 3'b100, 1'b0);
        chk("coincide_then_walk", 8'(walk), 8'd1);
        cyc(1'b0, 3'b001, 1'b0);

        // Illegal colour latches fault; requests ignored until reset.
        cyc(1'b0, 3'b011, 1'b0);
        chk("fault_set", 8'(fault), 8'd1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 3'b001, 1'b1);
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, 3'b100, 1'b1);
            chk("fault_no_walk", 8'(walk), 8'd0);
        end
        chk("fault_no_pend", 8'(req_pending), 8'd0);
        cyc(1'b1, 3'b100, 1'b0);
        chk("fault_cleared", 8'(fault), 8'd0);

        // Button in WALK is ignored; button in DONE re-arms for the next red.
        cyc(1'b0, 3'b001, 1'b1);
        cyc(1'b0, 3'b100, 1'b0);
        for (int i = 0; i < 7; i++) cyc(1'b0, 3'b100, i == 0);
        chk("walk_btn_ignored", 8'(req_pending), 8'd0);
        cyc(1'b0, 3'b100, 1'b1);
        chk("done_btn_pend", 8'(req_pending), 8'd1);
        chk("done_hold_dw",  8'(dont_walk), 8'd1);
        cyc(1'b0, 3'b010, 1'b0);
        chk("done_to_wait_pend", 8'(req_pending), 8'd1);
        cyc(1'b0, 3'b100, 1'b0);
        chk("rewalk", 8'(walk), 8'd1);

        // Reset mid-WALK.
        cyc(1'b1, 3'b100, 1'b0);
        chk("reset_mid_walk", 8'(walk), 8'd0);

        // Random traffic: colour held in runs so full crossings occur.
        rcol = 3'b001;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                pick = int'($urandom_range(0, 199));
                if (pick < 90)       rcol = 3'b100;
                else if (pick < 150) rcol = 3'b001;
                else if (pick < 197) rcol = 3'b010;
                else                 rcol = 3'($urandom_range(0, 7));
            end
            cyc($urandom_range(0, 149) == 0, rcol, $urandom_range(0, 3) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
